spi_boot_loader: RTL and testbench
==================================

// Module: spi_boot_loader
// PURPOSE
//  Parametrised SPI-EEPROM boot loader and AHB-Lite master, next generation of the reset-time image loader.
//  After reset it issues a READ command to the EEPROM and parses a 4-byte header {num_bytes, start_addr}.
//  It then streams the image into instruction/data memory as 32-bit AHB-Lite single writes, holding the core in reset.
//  Adds over the previous loader: real AHB handshake (hready stall, hresp error), size checking,
//  SCLK pause on bus stall, and done/error status.
// PARAMETERS
//  CLK_DIV     20           clk cycles per SCLK period; even, >=4
//  EE_ADDR_B   2            EEPROM address bytes sent after opcode (1..3); address is always 0
//  HADDR_W     32           AHB address width
//  BASE_ADDR   32'h0        added to header start_addr to form first haddr
//  MAX_BYTES   32768        largest legal num_bytes
// PORTS
//  clk         in   1       system clock
//  reset       in   1       synchronous, active-low
//  sclk        out  1       SPI clock, mode 0 (idle low)
//  mosi        out  1       SPI data out
//  miso        in   1       SPI data in
//  ss_n        out  1       SPI select, active-low
//  haddr       out  HADDR_W AHB address
//  htrans      out  2       00 IDLE / 10 NONSEQ
//  hwrite      out  1       1 during NONSEQ
//  hsize       out  3       constant 3'b010 (word)
//  hburst      out  3       constant 3'b000 (SINGLE)
//  hprot       out  4       constant 4'b0011
//  hmastlock   out  1       constant 0
//  hwdata      out  32      write data, valid in data phase
//  hready      in   1       slave ready
//  hresp       in   1       slave error
//  core_rst    out  1       1 = hold core in reset
//  boot_done   out  1       image loaded successfully (sticky)
//  boot_err    out  1       size or bus error (sticky)
// BEHAVIOUR
//  Reset (reset==0): FSM->CMD; sclk=0, mosi=0, ss_n=1, htrans=00, hwrite=0, haddr=0, hwdata=0,
//   core_rst=1, boot_done=0, boot_err=0. Re-asserting reset mid-load aborts the load; the next load restarts from CMD.
//  SPI: ss_n low from the first CMD cycle. sclk is high for CLK_DIV/2 clks, low for CLK_DIV/2 clks.
//   MOSI changes on the falling edge; MISO is sampled on the rising edge. Bytes are MSB first.
//  FSM: CMD -> HDR -> DATA <-> WR -> DONE | ERR.
//   CMD : shift out 8'h03 followed by EE_ADDR_B zero bytes; mosi=0 afterwards.
//   HDR : receive 4 bytes, little-endian: num_bytes[15:0], start_addr[15:0].
//         num_bytes==0 -> DONE; num_bytes>MAX_BYTES -> ERR.
//   DATA: assemble a little-endian word from 4 received bytes.
//         A short final word (num_bytes%4!=0) has its missing upper bytes zero-padded.
//   WR  : sclk is held low (paused) and ss_n stays low.
//         Address phase: htrans=10, hwrite=1, haddr = BASE_ADDR + start_addr + 4*i, held until hready=1.
//         Data phase: htrans=00, hwdata=word, held until hready=1.
//         hresp=1 in the data phase -> ERR. Otherwise i++; -> DONE if 4*i>=num_bytes, else -> DATA.
//         Each write therefore takes 2 clks minimum.
//  DONE: ss_n=1, sclk=0, core_rst=0 the cycle after entry, boot_done=1; terminal until reset.
//  ERR : ss_n=1, core_rst stays 1, boot_err=1; terminal until reset.
//  The byte counter is 16 bits wide; haddr arithmetic is modulo 2^HADDR_W (wraps silently).
//  No write is issued outside WR. core_rst never deasserts while a transfer is outstanding.
// STRUCTURE
//  Package spi_loader_pkg holds:
//   - FSM state enum
//   - EE_READ_OP=8'h03
//   - HTRANS_IDLE/HTRANS_NONSEQ
//   - HSIZE_WORD
//   - HPROT_DEFAULT
//  Sub-module spi_byte_engine: CLK_DIV divider, 8-bit shift in/out, start/pause inputs, byte_done strobe.
//  The top level holds the FSM, header registers, word assembler and AHB master.
// TESTING
//  1 Header {0x0008,0x0200}, data 11 22 33 44 55 66 77 88, hready=1
//    -> writes 0x44332211@0x200, 0x88776655@0x204;
//       core_rst falls after the 2nd data phase; boot_done=1.
//  2 Same image with hready low for 5 clks in each address and data phase
//    -> haddr/hwdata stable through the stall, sclk frozen low, identical memory result.
//  3 num_bytes=6 -> 2nd write data = 0x00006655; done.
//  4 num_bytes=0 -> no htrans=10 ever; boot_done=1 right after the header.
//    num_bytes=MAX_BYTES+4 -> boot_err=1, core_rst stays 1.
//  5 hresp=1 on the 1st data phase -> boot_err=1, ss_n=1, no further writes.
//  6 reset pulsed during the 3rd word -> all outputs return to reset values;
//    full reload succeeds; check the MOSI opcode bits 0000_0011 and CLK_DIV timing on sclk.

Source files
------------

// File: rtl/spi_loader_pkg.sv
// Shared types and bus constants for the SPI-EEPROM boot loader.
// Pure declarations: no latency and no flow control of its own.
package spi_loader_pkg;

    typedef enum logic [2:0] {
        ST_CMD,
        ST_HDR,
        ST_DATA,
        ST_WR,
        ST_DONE,
        ST_ERR
    } state_t;

    localparam logic [7:0] EE_READ_OP    = 8'h03;
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [2:0] HSIZE_WORD    = 3'b010;
    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [3:0] HPROT_DEFAULT = 4'b0011;

endpackage

// File: rtl/spi_byte_engine.sv
// Mode-0 SPI byte shifter, CLK_DIV clks per bit, byte_done one clk after the 8th falling edge.
// i_pause freezes the divider (sclk holds its level); dropping i_start returns it to idle.
module spi_byte_engine #(
    parameter int CLK_DIV = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_start,
    input  logic       i_pause,
    input  logic [7:0] i_tx_byte,
    input  logic       i_miso,
    output logic       o_sclk,
    output logic       o_mosi,
    output logic       o_byte_done,
    output logic [7:0] o_rx_byte
);
    localparam int HALF = CLK_DIV / 2;
    localparam int CW   = (HALF > 1) ? $clog2(HALF) : 1;

    logic          r_busy;
    logic          r_sclk;
    logic          r_done;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_bit;
    logic [7:0]    r_tx;
    logic [7:0]    r_rx;

    always_ff @(posedge clk) begin
        r_done <= 1'b0;
        if (!reset) begin
            r_busy <= 1'b0;
            r_sclk <= 1'b0;
            r_cnt  <= '0;
            r_bit  <= '0;
            r_tx   <= '0;
            r_rx   <= '0;
        end else if (!i_start) begin
            r_busy <= 1'b0;
            r_sclk <= 1'b0;
            r_cnt  <= '0;
            r_bit  <= '0;
        end else if (!r_busy) begin
            r_busy <= 1'b1;
            r_tx   <= i_tx_byte;
            r_cnt  <= '0;
        end else if (!i_pause) begin
            if (r_cnt == CW'(HALF - 1)) begin
                r_cnt  <= '0;
                r_sclk <= !r_sclk;
                if (!r_sclk) begin
                    r_rx <= {r_rx[6:0], i_miso};
                end else begin
                    // The next byte is loaded on the last falling edge so bytes stream back to back.
                    r_bit  <= r_bit + 3'd1;
                    r_tx   <= (r_bit == 3'd7) ? i_tx_byte : {r_tx[6:0], 1'b0};
                    r_done <= (r_bit == 3'd7);
                end
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign o_sclk      = r_sclk;
    assign o_mosi      = r_busy & r_tx[7];
    assign o_byte_done = r_done;
    assign o_rx_byte   = r_rx;

endmodule

// File: rtl/spi_boot_loader.sv
// Reset-time loader: reads a header+image from SPI EEPROM and writes it out as AHB-Lite single words.
// Each write takes >=2 clks; hready stalls hold the bus phase and pause sclk low.
module spi_boot_loader
    import spi_loader_pkg::*;
#(
    parameter int                 CLK_DIV   = 20,
    parameter int                 EE_ADDR_B = 2,
    parameter int                 HADDR_W   = 32,
    parameter logic [HADDR_W-1:0] BASE_ADDR = '0,
    parameter int                 MAX_BYTES = 32768
) (
    input  logic               clk,
    input  logic               reset,
    output logic               sclk,
    output logic               mosi,
    input  logic               miso,
    output logic               ss_n,
    output logic [HADDR_W-1:0] haddr,
    output logic [1:0]         htrans,
    output logic               hwrite,
    output logic [2:0]         hsize,
    output logic [2:0]         hburst,
    output logic [3:0]         hprot,
    output logic               hmastlock,
    output logic [31:0]        hwdata,
    input  logic               hready,
    input  logic               hresp,
    output logic               core_rst,
    output logic               boot_done,
    output logic               boot_err
);
    state_t             r_state;
    state_t             w_next;
    logic [1:0]         r_cnt;
    logic [15:0]        r_num;
    logic [7:0]         r_start_lo;
    logic [15:0]        r_rcvd;
    logic [31:0]        r_word;
    logic [HADDR_W-1:0] r_haddr;
    logic               r_dphase;
    logic               r_first;
    logic               r_ss_n;
    logic               r_core_rst;
    logic               r_boot_done;
    logic               r_boot_err;

    logic               w_start;
    logic               w_pause;
    logic               w_byte_done;
    logic [7:0]         w_rx;
    logic [7:0]         w_tx;
    logic               w_last_byte;

    // Only the very first byte after reset is non-zero: the opcode; address bytes and dummies are 0.
    assign w_tx        = r_first ? EE_READ_OP : 8'h00;
    assign w_last_byte = ((r_rcvd + 16'd1) == r_num);

    spi_byte_engine #(.CLK_DIV(CLK_DIV)) u_engine (
        .clk         (clk),
        .reset       (reset),
        .i_start     (w_start),
        .i_pause     (w_pause),
        .i_tx_byte   (w_tx),
        .i_miso      (miso),
        .o_sclk      (sclk),
        .o_mosi      (mosi),
        .o_byte_done (w_byte_done),
        .o_rx_byte   (w_rx)
    );

    always_ff @(posedge clk) begin
        if (!reset) r_state <= ST_CMD;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_CMD:  if (w_byte_done && r_cnt == 2'(EE_ADDR_B)) w_next = ST_HDR;
            ST_HDR:  if (w_byte_done && r_cnt == 2'd3) begin
                         if (r_num == 16'd0)                w_next = ST_DONE;
                         else if (32'(r_num) > MAX_BYTES)   w_next = ST_ERR;
                         else                               w_next = ST_DATA;
                     end
            ST_DATA: if (w_byte_done && (r_cnt == 2'd3 || w_last_byte)) w_next = ST_WR;
            ST_WR:   if (r_dphase && hready) begin
                         if (hresp)                 w_next = ST_ERR;
                         else if (r_rcvd >= r_num)  w_next = ST_DONE;
                         else                       w_next = ST_DATA;
                     end
            default: w_next = r_state;
        endcase
    end

    always_comb begin
        htrans  = HTRANS_IDLE;
        hwrite  = 1'b0;
        w_start = 1'b0;
        w_pause = 1'b0;
        case (r_state)
            ST_CMD, ST_HDR, ST_DATA: w_start = 1'b1;
            ST_WR: begin
                w_start = 1'b1;
                w_pause = 1'b1;
                if (!r_dphase) begin
                    htrans = HTRANS_NONSEQ;
                    hwrite = 1'b1;
                end
            end
            default: w_start = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cnt       <= '0;
            r_num       <= '0;
            r_start_lo  <= '0;
            r_rcvd      <= '0;
            r_word      <= '0;
            r_haddr     <= '0;
            r_dphase    <= 1'b0;
            r_first     <= 1'b1;
            r_ss_n      <= 1'b1;
            r_core_rst  <= 1'b1;
            r_boot_done <= 1'b0;
            r_boot_err  <= 1'b0;
        end else begin
            r_first     <= 1'b0;
            r_ss_n      <= !(w_next inside {ST_CMD, ST_HDR, ST_DATA, ST_WR});
            r_core_rst  <= (r_state != ST_DONE);
            r_boot_done <= r_boot_done | (w_next == ST_DONE);
            r_boot_err  <= r_boot_err | (w_next == ST_ERR);
            if (w_byte_done) begin
                case (r_state)
                    ST_CMD: r_cnt <= (r_cnt == 2'(EE_ADDR_B)) ? 2'd0 : r_cnt + 2'd1;
                    ST_HDR: begin
                        r_cnt <= r_cnt + 2'd1;
                        case (r_cnt)
                            2'd0:    r_num[7:0]  <= w_rx;
                            2'd1:    r_num[15:8] <= w_rx;
                            2'd2:    r_start_lo  <= w_rx;
                            default: r_haddr     <= BASE_ADDR + HADDR_W'({w_rx, r_start_lo});
                        endcase
                    end
                    ST_DATA: begin
                        r_word[{r_cnt, 3'b000} +: 8] <= w_rx;
                        r_cnt  <= r_cnt + 2'd1;
                        r_rcvd <= r_rcvd + 16'd1;
                    end
                    default: r_cnt <= r_cnt;
                endcase
            end
            if (r_state == ST_WR && hready) begin
                if (!r_dphase) begin
                    r_dphase <= 1'b1;
                end else begin
                    // Clearing the word here zero-pads a short final word.
                    r_dphase <= 1'b0;
                    r_haddr  <= r_haddr + HADDR_W'(4);
                    r_word   <= '0;
                    r_cnt    <= 2'd0;
                end
            end
        end
    end

    assign ss_n      = r_ss_n;
    assign haddr     = r_haddr;
    assign hwdata    = r_word;
    assign hsize     = HSIZE_WORD;
    assign hburst    = HBURST_SINGLE;
    assign hprot     = HPROT_DEFAULT;
    assign hmastlock = 1'b0;
    assign core_rst  = r_core_rst;
    assign boot_done = r_boot_done;
    assign boot_err  = r_boot_err;

endmodule

// File: tb/tb_spi_boot_loader.sv
// Bench for spi_boot_loader: EEPROM model, AHB slave with stall/error injection, write scoreboard.
module tb_spi_boot_loader;
    localparam int CLK_DIV   = 20;
    localparam int HALF      = CLK_DIV / 2;
    localparam int EE_ADDR_B = 2;
    localparam int CMD_BITS  = 8 * (1 + EE_ADDR_B);

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        miso = 1'b0;
    logic        hready = 1'b1;
    logic        hresp = 1'b0;
    logic        sclk, mosi, ss_n, hwrite, hmastlock, core_rst, boot_done, boot_err;
    logic [31:0] haddr, hwdata;
    logic [1:0]  htrans;
    logic [2:0]  hsize, hburst;
    logic [3:0]  hprot;

    always #5 clk = ~clk;

    spi_boot_loader #(
        .CLK_DIV(CLK_DIV), .EE_ADDR_B(EE_ADDR_B), .HADDR_W(32),
        .BASE_ADDR(32'h0), .MAX_BYTES(32768)
    ) dut (
        .clk(clk), .reset(reset), .sclk(sclk), .mosi(mosi), .miso(miso), .ss_n(ss_n),
        .haddr(haddr), .htrans(htrans), .hwrite(hwrite), .hsize(hsize), .hburst(hburst),
        .hprot(hprot), .hmastlock(hmastlock), .hwdata(hwdata), .hready(hready), .hresp(hresp),
        .core_rst(core_rst), .boot_done(boot_done), .boot_err(boot_err)
    );

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t        exp_q[$];
    logic [7:0] img[$];
    int n_checks = 0, n_errors = 0;
    int stall = 0, n_addr = 0, n_data_ok = 0, n_err_resp = 0;
    bit err_mode = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic ee_bit(input int n);
        int k;
        logic [7:0] b;
        if (n < CMD_BITS) return 1'b0;
        k = n - CMD_BITS;
        if (k / 8 >= img.size()) return 1'b0;
        b = img[k / 8];
        return b[7 - (k % 8)];
    endfunction

    // EEPROM: presents the next bit after every sclk falling edge while selected.
    int bitn = 0;
    always begin
        @(negedge ss_n);
        bitn = 0;
        miso = ee_bit(0);
        while (ss_n == 1'b0) begin
            @(negedge sclk or posedge ss_n);
            if (ss_n == 1'b0) begin
                bitn++;
                miso = ee_bit(bitn);
            end
        end
    end

    // AHB slave and scoreboard monitor.
    logic [31:0] hold_addr, hold_data;
    bit in_data = 1'b0, acc = 1'b0, a_seen = 1'b0;
    int wcnt = 0;
    wr_t e;
    always @(negedge clk) begin
        if (!reset) begin
            in_data = 1'b0; acc = 1'b0; a_seen = 1'b0; wcnt = 0; hready = 1'b1; hresp = 1'b0;
        end else begin
            if (acc) begin
                acc = 1'b0; in_data = 1'b1; wcnt = 0; hold_data = hwdata;
            end
            if (in_data) begin
                chk("dphase_htrans", {62'd0, htrans}, 64'd0);
                chk("dphase_sclk_low", {63'd0, sclk}, 64'd0);
                if (wcnt > 0) chk("hwdata_stable", {32'd0, hwdata}, {32'd0, hold_data});
                if (wcnt < stall) begin
                    hready = 1'b0; hresp = 1'b0; wcnt++;
                end else begin
                    hready = 1'b1;
                    hresp  = err_mode && (n_data_ok + n_err_resp == 0);
                    in_data = 1'b0;
                    if (hresp) n_err_resp++;
                    else begin
                        n_data_ok++;
                        chk("core_rst_during_write", {63'd0, core_rst}, 64'd1);
                        if (exp_q.size() == 0) chk("unexpected_write", {32'd0, hold_addr}, 64'hFFFF_FFFF_FFFF_FFFF);
                        else begin
                            e = exp_q.pop_front();
                            chk("wr_addr", {32'd0, hold_addr}, {32'd0, e.addr});
                            chk("wr_data", {32'd0, hwdata}, {32'd0, e.data});
                        end
                    end
                end
            end else if (htrans == 2'b10) begin
                chk("aphase_sclk_low", {63'd0, sclk}, 64'd0);
                if (!a_seen) begin a_seen = 1'b1; hold_addr = haddr; end
                else chk("haddr_stable", {32'd0, haddr}, {32'd0, hold_addr});
                if (wcnt < stall) begin
                    hready = 1'b0; wcnt++;
                end else begin
                    hready = 1'b1; acc = 1'b1; a_seen = 1'b0; wcnt = 0; n_addr++;
                end
            end else begin
                hready = 1'b1; hresp = 1'b0; wcnt = 0;
            end
        end
    end

    task automatic build(input logic [15:0] num, input logic [15:0] start, input int n_data);
        img = {};
        img.push_back(num[7:0]);   img.push_back(num[15:8]);
        img.push_back(start[7:0]); img.push_back(start[15:8]);
        for (int i = 0; i < n_data; i++) img.push_back(8'(8'h11 * (i + 1)));
    endtask

    task automatic push_exp(input logic [31:0] a, input logic [31:0] d);
        wr_t w;
        w.addr = a; w.data = d;
        exp_q.push_back(w);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ctrl"}, {55'd0, sclk, mosi, ss_n, htrans, hwrite, core_rst, boot_done, boot_err},
            {55'd0, 9'b0_0_1_00_0_1_0_0});
        chk({tag, "_bus"}, {haddr, hwdata}, 64'd0);
        chk({tag, "_const"}, {53'd0, hsize, hburst, hprot, hmastlock}, {53'd0, 3'b010, 3'b000, 4'b0011, 1'b0});
    endtask

    task automatic start_load();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_addr = 0; n_data_ok = 0; n_err_resp = 0;
        reset = 1'b1;
    endtask

    task automatic wait_end(output int cycles);
        cycles = 0;
        while (!(boot_done || boot_err) && cycles < 20000) begin
            @(negedge clk);
            cycles++;
        end
        chk("load_finished", {63'd0, boot_done | boot_err}, 64'd1);
    endtask

    int cyc;
    initial begin
        // Reset state
        reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_reset_vals("reset");

        // 1: basic 8-byte image, no stalls
        build(16'd8, 16'h0200, 8);
        push_exp(32'h200, 32'h4433_2211); push_exp(32'h204, 32'h8877_6655);
        start_load(); wait_end(cyc);
        chk("t1_done", {62'd0, boot_done, boot_err}, 64'b10);
        chk("t1_writes", 64'(n_data_ok), 64'd2);
        chk("t1_queue_empty", 64'(exp_q.size()), 64'd0);
        chk("t1_core_rst_entry", {63'd0, core_rst}, 64'd1);
        @(negedge clk);
        chk("t1_core_rst_released", {63'd0, core_rst}, 64'd0);
        chk("t1_spi_idle", {62'd0, ss_n, sclk}, 64'b10);

        // 2: same image, 5-clk stall in every bus phase
        stall = 5;
        push_exp(32'h200, 32'h4433_2211); push_exp(32'h204, 32'h8877_6655);
        start_load(); wait_end(cyc);
        chk("t2_done", {62'd0, boot_done, boot_err}, 64'b10);
        chk("t2_writes", 64'(n_data_ok), 64'd2);
        chk("t2_queue_empty", 64'(exp_q.size()), 64'd0);
        stall = 0;

        // 3: short final word is zero padded
        build(16'd6, 16'h0200, 8);
        push_exp(32'h200, 32'h4433_2211); push_exp(32'h204, 32'h0000_6655);
        start_load(); wait_end(cyc);
        chk("t3_done", {62'd0, boot_done, boot_err}, 64'b10);
        chk("t3_queue_empty", 64'(exp_q.size()), 64'd0);

        // 4a: empty image finishes right after the header
        build(16'd0, 16'h0200, 8);
        start_load(); wait_end(cyc);
        chk("t4a_done", {62'd0, boot_done, boot_err}, 64'b10);
        chk("t4a_no_nonseq", 64'(n_addr), 64'd0);
        chk("t4a_latency", {63'd0, (cyc >= 1118 && cyc <= 1126)}, 64'd1);

        // 4b: oversize image
        build(16'd32772, 16'h0200, 8);
        start_load(); wait_end(cyc);
        repeat (5) @(negedge clk);
        chk("t4b_status", {61'd0, boot_done, boot_err, core_rst}, 64'b011);
        chk("t4b_no_nonseq", 64'(n_addr), 64'd0);
        chk("t4b_ss_n", {63'd0, ss_n}, 64'd1);

        // 5: bus error on the first data phase
        err_mode = 1'b1;
        build(16'd8, 16'h0200, 8);
        start_load(); wait_end(cyc);
        repeat (200) @(negedge clk);
        chk("t5_status", {60'd0, boot_done, boot_err, core_rst, ss_n}, 64'b0111);
        chk("t5_addr_phases", 64'(n_addr), 64'd1);
        chk("t5_err_resp", 64'(n_err_resp), 64'd1);
        chk("t5_no_writes", 64'(n_data_ok), 64'd0);
        err_mode = 1'b0;

        // 6: reset during the third word, then full reload with SPI timing checks
        build(16'd12, 16'h0200, 12);
        push_exp(32'h200, 32'h4433_2211); push_exp(32'h204, 32'h8877_6655);
        push_exp(32'h208, 32'hCCBB_AA99);
        start_load();
        cyc = 0;
        while (n_data_ok < 2 && cyc < 10000) begin @(negedge clk); cyc++; end
        chk("t6_two_writes", 64'(n_data_ok), 64'd2);
        repeat (100) @(negedge clk);
        reset = 1'b0;
        @(posedge clk); @(negedge clk);
        chk_reset_vals("t6_midload_reset");
        chk("t6_third_pending", 64'(exp_q.size()), 64'd1);
        exp_q.delete();
        push_exp(32'h200, 32'h4433_2211); push_exp(32'h204, 32'h8877_6655);
        push_exp(32'h208, 32'hCCBB_AA99);
        @(posedge clk); @(negedge clk);
        n_addr = 0; n_data_ok = 0; n_err_resp = 0;
        reset = 1'b1;
        begin
            int lead = 0, hi = 0, lo = 0, phase = 0, nbits = 0;
            logic prev = 1'b0;
            logic [7:0] op = 8'h00;
            for (int i = 0; i < 600; i++) begin
                @(negedge clk);
                if (phase == 0) begin
                    if (sclk) begin phase = 1; hi = 1; end
                    else if (!ss_n) lead++;
                end else if (phase == 1) begin
                    if (sclk) hi++;
                    else begin phase = 2; lo = 1; end
                end else if (phase == 2) begin
                    if (!sclk) lo++;
                    else phase = 3;
                end
                if (sclk && !prev && nbits < 8) begin op = {op[6:0], mosi}; nbits++; end
                prev = sclk;
            end
            chk("t6_sclk_lead", 64'(lead), 64'(HALF));
            chk("t6_sclk_high", 64'(hi), 64'(HALF));
            chk("t6_sclk_low", 64'(lo), 64'(HALF));
            chk("t6_opcode", {56'd0, op}, 64'h03);
        end
        wait_end(cyc);
        chk("t6_done", {62'd0, boot_done, boot_err}, 64'b10);
        chk("t6_writes", 64'(n_data_ok), 64'd3);
        chk("t6_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
